// File: rtl/wifi_tx_conv_encoder_pkg.sv
// ============================================================================
// Module   : wifi_tx_conv_encoder_pkg
// Brief    : Shared constants for the WIFI TX K=7 rate-1/2 convolutional encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wifi_tx_conv_encoder_pkg;

    localparam int         c_K        = 7;
    localparam logic [6:0] c_G0       = 7'o133;
    localparam logic [6:0] c_G1       = 7'o171;
    localparam int         c_TAIL_LEN = c_K - 1;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RUN    = 3'd1;
    localparam logic [2:0] c_ST_EMIT_B = 3'd2;
    localparam logic [2:0] c_ST_TAIL   = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // Window MSB is the current input bit, LSB the oldest history bit.
    function automatic logic tap_parity(input logic [6:0] taps, input logic [6:0] win);
        return ^(taps & win);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wifi_tx_conv_core.sv
// ============================================================================
// Module   : wifi_tx_conv_core
// Brief    : Combinational K=7 generator pair; produces coded bits A and B.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wifi_tx_conv_core
    import wifi_tx_conv_encoder_pkg::*;
(
    input  logic       i_d,
    input  logic [5:0] i_sr,
    output logic       o_a,
    output logic       o_b
);

    logic [6:0] w_win;

    assign w_win = {i_d, i_sr[0], i_sr[1], i_sr[2], i_sr[3], i_sr[4], i_sr[5]};
    assign o_a   = tap_parity(c_G0, w_win);
    assign o_b   = tap_parity(c_G1, w_win);

endmodule

`default_nettype wire

// File: rtl/wifi_tx_conv_encoder.sv
// ============================================================================
// Module   : wifi_tx_conv_encoder
// Brief    : Rate-1/2 K=7 convolutional encoder, serial A,B output with zero tail.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wifi_tx_conv_encoder
    import wifi_tx_conv_encoder_pkg::*;
#(
    parameter int TAIL_EN  = 1,
    parameter int TAIL_LEN = c_TAIL_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic valid_in,
    input  logic data_in,
    output logic ready_in,
    output logic valid_out,
    output logic data_out,
    output logic finished
);

    localparam int c_CNT_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    logic [2:0]         r_state_q,    w_state_d;
    logic [5:0]         r_sr_q,       w_sr_d;
    logic               r_b_hold_q,   w_b_hold_d;
    logic [c_CNT_W-1:0] r_tail_cnt_q, w_tail_cnt_d;
    logic               r_ph_q,       w_ph_d;
    logic               r_valid_q,    w_valid_d;
    logic               r_data_q,     w_data_d;
    logic               r_fin_q,      w_fin_d;
    logic               w_d, w_a, w_b;

    // The tail path reuses the same generator logic with a forced zero input.
    assign w_d = (r_state_q == c_ST_TAIL) ? 1'b0 : data_in;

    wifi_tx_conv_core u_core (
        .i_d  (w_d),
        .i_sr (r_sr_q),
        .o_a  (w_a),
        .o_b  (w_b)
    );

    assign ready_in  = (r_state_q == c_ST_RUN) && enable;
    assign valid_out = r_valid_q;
    assign data_out  = r_data_q;
    assign finished  = r_fin_q;

    always_comb begin
        w_state_d    = r_state_q;
        w_sr_d       = r_sr_q;
        w_b_hold_d   = r_b_hold_q;
        w_tail_cnt_d = r_tail_cnt_q;
        w_ph_d       = r_ph_q;
        w_valid_d    = 1'b0;
        w_data_d     = r_data_q;
        w_fin_d      = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (enable) begin
                    w_sr_d    = '0;
                    w_state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (!enable) begin
                    w_tail_cnt_d = '0;
                    w_ph_d       = 1'b0;
                    w_state_d    = (TAIL_EN != 0) ? c_ST_TAIL : c_ST_DONE;
                end else if (valid_in) begin
                    w_sr_d     = {r_sr_q[4:0], w_d};
                    w_data_d   = w_a;
                    w_valid_d  = 1'b1;
                    w_b_hold_d = w_b;
                    w_state_d  = c_ST_EMIT_B;
                end
            end
            c_ST_EMIT_B: begin
                w_data_d  = r_b_hold_q;
                w_valid_d = 1'b1;
                w_state_d = c_ST_RUN;
            end
            c_ST_TAIL: begin
                w_valid_d = 1'b1;
                if (!r_ph_q) begin
                    w_data_d   = w_a;
                    w_b_hold_d = w_b;
                    w_sr_d     = {r_sr_q[4:0], w_d};
                    w_ph_d     = 1'b1;
                end else begin
                    w_data_d = r_b_hold_q;
                    w_ph_d   = 1'b0;
                    if (r_tail_cnt_q == c_CNT_W'(TAIL_LEN - 1)) begin
                        w_state_d = c_ST_DONE;
                    end else begin
                        w_tail_cnt_d = r_tail_cnt_q + c_CNT_W'(1);
                    end
                end
            end
            c_ST_DONE: begin
                w_fin_d   = 1'b1;
                w_state_d = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= c_ST_IDLE;
            r_sr_q       <= '0;
            r_b_hold_q   <= 1'b0;
            r_tail_cnt_q <= '0;
            r_ph_q       <= 1'b0;
            r_valid_q    <= 1'b0;
            r_data_q     <= 1'b0;
            r_fin_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_sr_q       <= w_sr_d;
            r_b_hold_q   <= w_b_hold_d;
            r_tail_cnt_q <= w_tail_cnt_d;
            r_ph_q       <= w_ph_d;
            r_valid_q    <= w_valid_d;
            r_data_q     <= w_data_d;
            r_fin_q      <= w_fin_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/wifi_tx_conv_encoder.md
Name: wifi_tx_conv_encoder

Overview:
- Rate-1/2 convolutional encoder for the WIFI TX chain: K=7, generators g0=133 (octal), g1=171 (octal).
- Sits directly upstream of the rate-3/4 puncturer. Consumes scrambled serial bits and emits the serial coded stream A,B,A,B,... in the puncturer's valid/data/finished format.
- On frame end it appends the 6 zero tail bits, so the trellis terminates in state 0.

Parameters:
- TAIL_EN, 1: 1 = append 6 zero tail bits after enable falls; 0 = go straight to finish.
- TAIL_LEN, 6: number of tail bits, equal to K-1. Fixed at 6 for 802.11; exposed only for verification.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  frame active; rising edge starts a frame, falling edge ends it.
- valid_in  input  1  data_in is valid this cycle.
- data_in  input  1  uncoded serial bit.
- ready_in  output  1  encoder accepts data_in this cycle.
- valid_out  output  1  data_out is a coded bit.
- data_out  output  1  coded bit.
- finished  output  1  one-cycle pulse after the last coded bit of the frame.

Behaviour:
- Reset: synchronous, active-high. All of the following go to 0 on the next edge: state=IDLE, sr[5:0], b_hold, tail counter, valid_out, data_out, finished, ready_in.
- Shift register: sr[0] holds the newest past bit, sr[5] the oldest. With current input d:
  - A = d^sr[1]^sr[2]^sr[4]^sr[5]
  - B = d^sr[0]^sr[1]^sr[2]^sr[5]
  - Update: sr <= {sr[4:0], d}.
- Accept rule: a bit is accepted when valid_in && ready_in. ready_in is combinational and equals (state==RUN && enable).
- Timing:
  - A is registered: data_out=A and valid_out=1 in the cycle after accept.
  - B is stored in b_hold and output the following cycle.
  - Throughput: 1 input bit per 2 cycles. With continuous input, valid_out is high every cycle.
- FSM states:
  - IDLE: outputs low. If enable=1: clear sr, go to RUN.
  - RUN: if enable=0, go to TAIL (or DONE if TAIL_EN=0). Else, on accept, go to EMIT_B.
  - EMIT_B: data_out=b_hold, valid_out=1, ready_in=0. Return to RUN. The RUN check sees enable=0 and proceeds to the tail, so a frame ending mid-pair never truncates B.
  - TAIL: a d=0 bit is fed internally with phase bit ph.
    - ph=0 emits A, ph=1 emits B.
    - After the TAIL_LEN-th B, go to DONE.
    - valid_in and ready_in are ignored/low.
    - The tail counter runs 0..TAIL_LEN-1.
  - DONE: finished=1 for exactly one cycle, valid_out=0, then go to IDLE.
- Timing rules:
  - enable re-asserted during TAIL or DONE: ignored until IDLE. The new frame starts on the first IDLE cycle with enable=1.
  - valid_in while enable=0: ignored, no accept.
  - valid_out=0 in any cycle with no coded bit. data_out then holds its last value, and downstream must gate on valid_out.
- Frame bit count: output bits = 2*(N + TAIL_LEN*TAIL_EN) for N accepted bits.
- Reset mid-frame: all state is lost immediately and no finished pulse is produced.
- No backpressure from downstream; the puncturer consumes every valid_out bit.

Decomposition:
- Shared WIFI TX package holds: G0=7'o133, G1=7'o171, K=7, TAIL_LEN default, FSM state encoding.
- One natural sub-module: wifi_tx_conv_core. It is combinational, takes d and sr and produces A and B, and is reused by the tail path and by the testbench reference model.
- The FSM, b_hold and tail counter live in the top module.

Test Plan:
- Impulse: frame with single bit 1, TAIL_EN=1 -> output 11 01 11 11 00 10 11 (14 bits, generator taps interleaved), then finished high 1 cycle after the last bit.
- All-zeros frame of 24 bits -> 60 output bits (24 data + 6 tail bits, ×2), all 0; finished pulses once.
- Continuous input (valid_in held 1, 48 random bits) -> ready_in toggles 1,0,1,0; valid_out high every cycle; the stream matches the bit-exact model; 108 bits total.
- enable drops in the EMIT_B cycle -> that B is still output, the 12 tail bits follow, and the total count is correct.
- TAIL_EN=0, 8-bit frame -> 16 output bits, then finished with no tail. enable re-asserted during DONE -> new frame starts only from IDLE with sr cleared.
- Reset asserted mid-TAIL -> next cycle all outputs 0, state IDLE, no finished pulse. A following frame encodes correctly from sr=0.
